router_pkt_reader: RTL

- Destination-side packet consumer for one router output FIFO.
- Drains the FIFO, parses the packet format {header = payload_length[7:2], addr[1:0]; payload_length payload bytes; parity byte}, and forwards every byte to a client with start/end framing.
- Checks the XOR parity over header and payload, and checks the address field.
- Reads promptly so the router's un-read soft-reset timeout does not fire during normal operation.

---
 rtl/router_pkt_reader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/router_pkt_reader.sv
// Destination-side reader for one router output FIFO: drains a packet, frames it
// for a client with sop/eop and checks parity, address and mid-packet stalls.
module router_pkt_reader #(
  parameter logic [1:0] PORT_ID = 2'd0,
  parameter int         TIMEOUT = 64,
  parameter int         CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_data,
  output logic             fifo_rd_en,
  input  logic             sink_ready,
  output logic [7:0]       pkt_byte,
  output logic             pkt_valid,
  output logic             pkt_sop,
  output logic             pkt_eop,
  output logic [5:0]       pkt_len,
  output logic [1:0]       pkt_addr,
  output logic             pkt_done,
  output logic             parity_err,
  output logic             addr_err,
  output logic             trunc_err,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, HDR, BODY, DONE} state_t;

  state_t           state_q, state_d;
  logic             rd_vld_q;
  logic [7:0]       acc_q, acc_d;
  logic [6:0]       req_left_q, req_left_d, rcv_left_q, rcv_left_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [5:0]       len_q, len_d;
  logic [1:0]       addr_q, addr_d;
  logic             perr_q, perr_d, aerr_q, aerr_d, terr_q, terr_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d, ecnt_q, ecnt_d;
  logic             rd_acc, tmo_hit;

  // The abort cycle also blocks reads so no byte of the next packet is swallowed by DONE.
  assign tmo_hit    = (state_q == BODY) & ~rd_vld_q & (tmo_q == TW'(TIMEOUT - 1));
  assign fifo_rd_en = ~reset & ~fifo_empty & sink_ready &
                      ((state_q == IDLE) | ((state_q == BODY) & (req_left_q != 7'd0) & ~tmo_hit));
  assign rd_acc     = fifo_rd_en & ~fifo_empty;

  assign pkt_valid  = rd_vld_q;
  assign pkt_byte   = rd_vld_q ? fifo_data : 8'd0;
  assign pkt_len    = len_q;
  assign pkt_addr   = addr_q;
  assign parity_err = perr_q;
  assign addr_err   = aerr_q;
  assign trunc_err  = terr_q;
  assign busy       = (state_q != IDLE);
  assign pkt_cnt    = pcnt_q;
  assign err_cnt    = ecnt_q;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    req_left_d = req_left_q;
    rcv_left_d = rcv_left_q;
    tmo_d      = tmo_q;
    len_d      = len_q;
    addr_d     = addr_q;
    perr_d     = perr_q;
    aerr_d     = aerr_q;
    terr_d     = terr_q;
    pcnt_d     = pcnt_q;
    ecnt_d     = ecnt_q;
    pkt_sop    = 1'b0;
    pkt_eop    = 1'b0;
    pkt_done   = 1'b0;
    case (state_q)
      IDLE: if (rd_acc) state_d = HDR;
      HDR: begin
        pkt_sop    = rd_vld_q;
        len_d      = fifo_data[7:2];
        addr_d     = fifo_data[1:0];
        acc_d      = fifo_data;
        req_left_d = {1'b0, fifo_data[7:2]} + 7'd1;
        rcv_left_d = {1'b0, fifo_data[7:2]} + 7'd1;
        tmo_d      = '0;
        state_d    = BODY;
      end
      BODY: begin
        if (rd_acc) req_left_d = req_left_q - 7'd1;
        if (rd_vld_q) begin
          tmo_d = '0;
          if (rcv_left_q > 7'd1) begin
            acc_d      = acc_q ^ fifo_data;
            rcv_left_d = rcv_left_q - 7'd1;
          end else begin
            pkt_eop    = 1'b1;
            perr_d     = (acc_q != fifo_data);
            aerr_d     = (addr_q != PORT_ID);
            terr_d     = 1'b0;
            rcv_left_d = 7'd0;
            state_d    = DONE;
          end
        end else if (tmo_hit) begin
          perr_d     = 1'b0;
          aerr_d     = (addr_q != PORT_ID);
          terr_d     = 1'b1;
          rcv_left_d = 7'd0;
          tmo_d      = '0;
          state_d    = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DONE: begin
        pkt_done = 1'b1;
        pcnt_d   = pcnt_q + 1'b1;
        if ((perr_q | aerr_q | terr_q) && (ecnt_q != '1)) ecnt_d = ecnt_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_vld_q   <= 1'b0;
      acc_q      <= '0;
      req_left_q <= '0;
      rcv_left_q <= '0;
      tmo_q      <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      perr_q     <= 1'b0;
      aerr_q     <= 1'b0;
      terr_q     <= 1'b0;
      pcnt_q     <= '0;
      ecnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      rd_vld_q   <= rd_acc;
      acc_q      <= acc_d;
      req_left_q <= req_left_d;
      rcv_left_q <= rcv_left_d;
      tmo_q      <= tmo_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      perr_q     <= perr_d;
      aerr_q     <= aerr_d;
      terr_q     <= terr_d;
      pcnt_q     <= pcnt_d;
      ecnt_q     <= ecnt_d;
    end
  end
endmodule
